mem_wb_pipe_stage: RTL and testbench
====================================

Name: mem_wb_pipe_stage

Overview:
Parametrised elastic MEM→WB pipeline register; successor to the fixed free-running MEM/WB latch.
Adds a valid/ready handshake, a 2-entry skid buffer so backpressure from WB never drops data, a synchronous flush, and control gating so a bubble can never write the register file.
Sits between the data-memory stage and register-file writeback.
Generic enough for reuse as IF/ID, ID/EX or EX/MEM with other widths.

Parameters:
DATA_W, 64, width of the ALU-result and memory-read-data payloads
RD_W, 5, destination-register index width
CTRL_W, 2, control-bit width; bit0 = RegWrite, bit1 = MemtoReg

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  upstream (EX/MEM) holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_rd  in  RD_W  destination register
in_alu  in  DATA_W  ALU/mux result
in_rdata  in  DATA_W  data-memory read data
in_ctrl  in  CTRL_W  control bits
flush  in  1  discard all held and incoming entries
out_valid  out  1  output entry valid
out_ready  in  1  writeback consumes entry
out_rd  out  RD_W  held destination register
out_alu  out  DATA_W  held ALU result
out_rdata  out  DATA_W  held read data
out_ctrl  out  CTRL_W  held control, forced 0 when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage:
  - main entry M drives the outputs.
  - skid entry S is used only under backpressure.
  - each entry has a valid bit (mv, sv) and a payload {rd, alu, rdata, ctrl}.
- Handshake:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
  - in_ready = ~sv & ~reset; it depends only on registered state, never on out_ready combinationally.
  - out_valid = mv.
  - occupancy = mv + sv.
- Latency: an accepted entry appears on the outputs the next cycle when the stage was empty or M was being consumed. Throughput is 1 entry/cycle with out_ready held high.
- Next-state rules, per edge, when neither reset nor flush is asserted:
  - empty, accept → M ← input.
  - M only, consume & accept → M ← input.
  - M only, consume & ~accept → mv ← 0.
  - M only, ~consume & accept → S ← input, sv ← 1; M unchanged.
  - M and S, consume → M ← S, sv ← 0. No accept is possible because in_ready=0.
  - M and S, ~consume → hold.
- Ordering: strict FIFO. S never overtakes M.
- out_ctrl = mv ? M.ctrl : 0, so RegWrite and MemtoReg are never 1 on a bubble. out_rd, out_alu and out_rdata show the last held payload and are don't-care for checking when out_valid=0.
- Flush:
  - at the next edge, mv ← 0 and sv ← 0.
  - any same-cycle accept is discarded.
  - payload registers need not clear.
  - in_ready stays combinational per the rule above and may be 1 during flush.
- Reset:
  - reset is synchronous and active-high.
  - at the next edge, mv=sv=0 and all payload registers are 0.
  - while reset is high: in_ready=0, out_valid=0, out_ctrl=0, occupancy=0.
  - reset overrides flush and all handshakes.
  - reset mid-transfer loses both entries with no partial update.
- Simultaneous flush and consume: flush wins and the stage is empty next cycle. The consumer may still treat the current cycle's out_* as taken.
- No arithmetic on payload; pure storage. Widths pass through unchanged.

Test Plan:
1. Reset then stream, out_ready=1, sending in_rd=3/alu=0x10/ctrl=01, then rd=4/alu=0x20, then rd=5/alu=0x30 → each appears 1 cycle later in order, occupancy=1 throughout, in_ready=1.
2. Backpressure: out_ready=0 while sending A(rd=7) and B(rd=8) → occupancy 1 then 2, in_ready=0 after B. Then raise out_ready → A consumed, then B, occupancy 2→1→0, no loss or reorder.
3. Bubble gating: hold in_ctrl=11 with in_valid=0 → out_valid=0 and out_ctrl=00 every cycle.
4. Flush with 2 entries held plus in_valid=1 → next cycle occupancy=0, out_valid=0, and the flushed input never appears.
5. Synchronous reset asserted with occupancy=2 → next edge: all outputs 0, in_ready=0 while reset is high, in_ready=1 the cycle after release. No asynchronous effect mid-cycle.
6. Random valid/ready toggling for 10k cycles with DATA_W=32, RD_W=5 → scoreboard shows output sequence equal to accepted sequence, and out_ctrl never nonzero while out_valid=0.

Source files
------------

// File: rtl/mem_wb_pipe_stage_if.sv
// Handshake and payload bundle for an elastic pipeline stage.
// The stage connects through slave; the producer/consumer side uses master.
interface mem_wb_pipe_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_rdata;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_rdata;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_rd, in_alu, in_rdata, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_rd, out_alu, out_rdata, out_ctrl, occupancy
  );

  modport master (
    output in_valid, in_rd, in_alu, in_rdata, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_rd, out_alu, out_rdata, out_ctrl, occupancy
  );
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// Elastic MEM->WB pipeline register: main entry M drives outputs, skid entry S
// absorbs one extra entry under backpressure; bubbles never carry control bits.
module mem_wb_pipe_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 2
) (
  input logic                clk,
  input logic                reset,
  mem_wb_pipe_stage_if.slave bus
);
  logic              mv, sv;
  logic [RD_W-1:0]   m_rd, s_rd;
  logic [DATA_W-1:0] m_alu, s_alu, m_rdata, s_rdata;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              accept, consume;

  assign bus.in_ready  = ~sv & ~reset;
  assign bus.out_valid = mv & ~reset;
  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = bus.out_valid & bus.out_ready;

  assign bus.out_rd    = m_rd;
  assign bus.out_alu   = m_alu;
  assign bus.out_rdata = m_rdata;
  assign bus.out_ctrl  = bus.out_valid ? m_ctrl : '0;
  assign bus.occupancy = reset ? 2'd0 : ({1'b0, mv} + {1'b0, sv});

  always_ff @(posedge clk) begin
    if (reset) begin
      mv      <= 1'b0;
      sv      <= 1'b0;
      m_rd    <= '0;
      m_alu   <= '0;
      m_rdata <= '0;
      m_ctrl  <= '0;
      s_rd    <= '0;
      s_alu   <= '0;
      s_rdata <= '0;
      s_ctrl  <= '0;
    end else if (bus.flush) begin
      mv <= 1'b0;
      sv <= 1'b0;
    end else if (!mv) begin
      if (accept) begin
        mv      <= 1'b1;
        m_rd    <= bus.in_rd;
        m_alu   <= bus.in_alu;
        m_rdata <= bus.in_rdata;
        m_ctrl  <= bus.in_ctrl;
      end
    end else if (!sv) begin
      if (consume && accept) begin
        m_rd    <= bus.in_rd;
        m_alu   <= bus.in_alu;
        m_rdata <= bus.in_rdata;
        m_ctrl  <= bus.in_ctrl;
      end else if (consume) begin
        mv <= 1'b0;
      end else if (accept) begin
        sv      <= 1'b1;
        s_rd    <= bus.in_rd;
        s_alu   <= bus.in_alu;
        s_rdata <= bus.in_rdata;
        s_ctrl  <= bus.in_ctrl;
      end
    end else if (consume) begin
      // Skid entry moves up; in_ready was low so no accept can race it.
      sv      <= 1'b0;
      m_rd    <= s_rd;
      m_alu   <= s_alu;
      m_rdata <= s_rdata;
      m_ctrl  <= s_ctrl;
    end
  end
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Randomised and directed checks of mem_wb_pipe_stage against a queue model.
module tb_mem_wb_pipe_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdata;
    logic [CW-1:0] ctrl;
  } ent_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  ent_t q[$];

  mem_wb_pipe_stage_if #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) bus ();

  mem_wb_pipe_stage #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a FIFO of capacity 2; pop on consume, push on accept, clear on reset/flush.
  task automatic tick();
    ent_t e;
    bit   acc, con;
    acc = bus.in_valid && (q.size() < 2) && !reset;
    con = (q.size() > 0) && bus.out_ready && !reset;
    e   = '{rd: bus.in_rd, alu: bus.in_alu, rdata: bus.in_rdata, ctrl: bus.in_ctrl};
    @(posedge clk);
    if (reset || bus.flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rd, input int alu, input int ctrl);
    bus.in_valid = v;
    bus.in_rd    = RW'(rd);
    bus.in_alu   = DW'(alu);
    bus.in_rdata = DW'(alu) ^ 32'hA5A5_0000;
    bus.in_ctrl  = CW'(ctrl);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_ctrl !== 2'b00) begin errors++; $display("FAIL reset_out_ctrl got=%b exp=00", bus.out_ctrl); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_stream();
    int rds [3] = '{3, 4, 5};
    int alus[3] = '{32'h10, 32'h20, 32'h30};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, rds[i], alus[i], 1);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== RW'(rds[i]) || bus.out_alu !== DW'(alus[i]))
        begin errors++; $display("FAIL stream_%0d got v=%b rd=%0d alu=%h exp rd=%0d alu=%h", i, bus.out_valid, bus.out_rd, bus.out_alu, rds[i], alus[i]); end
      checks++; if (bus.out_ctrl !== 2'b01) begin errors++; $display("FAIL stream_ctrl_%0d got=%b exp=01", i, bus.out_ctrl); end
      checks++; if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_occ_%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, bus.occupancy, bus.in_ready); end
    end
    drive(0, 0, 0, 0);
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0)
      begin errors++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1, 7, 32'h70, 1);
    tick();
    checks++; if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_a got occ=%0d rdy=%b exp occ=1 rdy=1", bus.occupancy, bus.in_ready); end
    drive(1, 8, 32'h80, 3);
    tick();
    checks++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_rd !== 5'd7)
      begin errors++; $display("FAIL bp_b got occ=%0d rdy=%b rd=%0d exp occ=2 rdy=0 rd=7", bus.occupancy, bus.in_ready, bus.out_rd); end
    drive(0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.occupancy !== 2'd1 || bus.out_rd !== 5'd8 || bus.out_alu !== 32'h80 || bus.out_ctrl !== 2'b11)
      begin errors++; $display("FAIL bp_drain1 got occ=%0d rd=%0d alu=%h ctrl=%b exp occ=1 rd=8 alu=80 ctrl=11", bus.occupancy, bus.out_rd, bus.out_alu, bus.out_ctrl); end
    tick();
    checks++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_drain2 got occ=%0d v=%b exp occ=0 v=0", bus.occupancy, bus.out_valid); end
  endtask

  task automatic test_bubble();
    drive(0, 9, 32'h99, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 2'b00)
        begin errors++; $display("FAIL bubble_%0d got v=%b ctrl=%b exp v=0 ctrl=00", i, bus.out_valid, bus.out_ctrl); end
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1, 1, 32'h11, 1); tick();
    drive(1, 2, 32'h22, 1); tick();
    drive(1, 9, 32'h99, 3);
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_full got occ=%0d v=%b exp occ=0 v=0", bus.occupancy, bus.out_valid); end
    bus.flush = 1'b0;
    drive(1, 3, 32'h33, 1); tick();
    // One entry held, in_ready high: the same-cycle accept must also vanish.
    drive(1, 10, 32'hAA, 3);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_ctrl !== 2'b00)
      begin errors++; $display("FAIL flush_accept got occ=%0d v=%b ctrl=%b exp 0/0/00", bus.occupancy, bus.out_valid, bus.out_ctrl); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_sync_reset();
    bus.out_ready = 1'b0;
    drive(1, 12, 32'hC0, 3); tick();
    drive(1, 13, 32'hD0, 3); tick();
    checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL sreset_pre got occ=%0d exp=2", bus.occupancy); end
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sreset_rdy_mid got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_ctrl !== 2'b00 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL sreset_ctl got v=%b occ=%0d ctrl=%b rdy=%b exp 0/0/00/0", bus.out_valid, bus.occupancy, bus.out_ctrl, bus.in_ready); end
    checks++; if (bus.out_rd !== 5'd0 || bus.out_alu !== 32'd0 || bus.out_rdata !== 32'd0)
      begin errors++; $display("FAIL sreset_payload got rd=%0d alu=%h rdata=%h exp zeros", bus.out_rd, bus.out_alu, bus.out_rdata); end
    reset = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sreset_release got=%b exp=1", bus.in_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 1) == 1, int'($urandom), int'($urandom), int'($urandom));
      bus.in_rdata  = $urandom;
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.flush     = $urandom_range(0, 63) == 0;
      tick();
      checks++; if (bus.out_valid !== (q.size() > 0) || bus.occupancy !== 2'(q.size()) || bus.in_ready !== (q.size() < 2))
        begin errors++; $display("FAIL rand_state@%0d got v=%b occ=%0d rdy=%b exp occ=%0d", n, bus.out_valid, bus.occupancy, bus.in_ready, q.size()); end
      if (q.size() > 0) begin
        checks++; if ({bus.out_rd, bus.out_alu, bus.out_rdata, bus.out_ctrl} !== q[0])
          begin errors++; $display("FAIL rand_data@%0d got rd=%0d alu=%h rdata=%h ctrl=%b exp %h", n, bus.out_rd, bus.out_alu, bus.out_rdata, bus.out_ctrl, q[0]); end
      end else begin
        checks++; if (bus.out_ctrl !== 2'b00)
          begin errors++; $display("FAIL rand_bubble@%0d got ctrl=%b exp=00", n, bus.out_ctrl); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_sync_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
